pwl_logit_stream: RTL and testbench

- Streaming inverse of the GLU-path piecewise-linear sigmoid. Maps a Q4.12 probability-domain sample back to the Q4.12 pre-activation domain.
- Used by the discriminator-to-generator feedback path and by the activation self-check harness.
- Two-stage pipeline with valid/ready handshakes on both sides, plus a counter of clamped samples.

---
 rtl/pwl_logit_stream.sv | 68 ++++++
 tb/tb_pwl_logit_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwl_logit_stream.sv
// pwl_logit_stream: streaming inverse of the PWL sigmoid, Q4.12 probability -> Q4.12 pre-activation
module pwl_logit_stream #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_sat,
    input  logic                     clr_count,
    output logic [CNT_W-1:0]         sat_count
);
    localparam logic signed [DATA_W-1:0] Y_ONE = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W+1:0] Y_MID = (DATA_W+2)'(1 << (FRAC_W-1));
    localparam logic signed [DATA_W-1:0] X_HI  = DATA_W'(2 << FRAC_W);
    localparam logic signed [DATA_W-1:0] X_LO  = -X_HI;
    typedef enum logic [1:0] {LOW, LIN, HIGH} cls_t;
    logic                     en;
    logic                     v1;
    logic signed [DATA_W-1:0] y1;
    cls_t                     c1;
    cls_t                     c_in;
    logic signed [DATA_W+1:0] diff;
    logic signed [DATA_W-1:0] x_nxt;
    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    // classify the incoming sample and form the stage-2 result from stage 1
    always_comb begin
        c_in  = (s_data[DATA_W-1] || s_data == '0) ? LOW : (s_data >= Y_ONE) ? HIGH : LIN;
        diff  = {{2{y1[DATA_W-1]}}, y1} - Y_MID;
        x_nxt = c1 == LOW ? X_LO : c1 == HIGH ? X_HI : DATA_W'(diff <<< 2);
    end
    // both stages advance together; data registers only load under a valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            y1      <= '0;
            c1      <= LOW;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else if (en) begin
            v1      <= s_valid;
            m_valid <= v1;
            if (s_valid) begin
                y1 <= s_data;
                c1 <= c_in;
            end
            if (v1) begin
                m_data <= x_nxt;
                m_sat  <= c1 != LIN;
            end
        end
    end
    // saturating count of clamped output transfers; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || clr_count)
            sat_count <= '0;
        else if (m_valid && m_ready && m_sat && sat_count != '1)
            sat_count <= sat_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_pwl_logit_stream.sv
// tb_pwl_logit_stream: scoreboard bench for the streaming PWL logit block
module tb_pwl_logit_stream;
    logic               clk = 0;
    logic               rst = 1;
    logic               s_valid = 0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic               m_valid;
    logic               m_ready = 1;
    logic signed [15:0] m_data;
    logic               m_sat;
    logic               clr_count = 0;
    logic [3:0]         sat_count;

    pwl_logit_stream #(.DATA_W(16), .FRAC_W(12), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
        .clr_count(clr_count), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [15:0] x;
        logic               s;
        int                 c;
    } ent_t;

    ent_t q[$];
    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int exp_cnt = 0;
    bit mon_on = 0;
    bit lat_chk = 0;
    bit stall_prev = 0;
    logic signed [15:0] d_prev;
    logic s_prev;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_f(input logic signed [15:0] y);
        int v;
        v = y;
        if (v <= 0) return {1'b1, 16'hE000};
        if (v >= 4096) return {1'b1, 16'h2000};
        return {1'b0, 16'((v - 2048) * 4)};
    endfunction

    // scoreboard, hold checker and sat_count model, sampled on the falling edge
    always @(negedge clk) begin
        ent_t e;
        logic [16:0] r;
        bit xs;
        cyc++;
        if (mon_on) begin
            chk("sat_count", sat_count, exp_cnt);
            if (stall_prev) begin
                chk("hold_data", m_data, d_prev);
                chk("hold_sat", m_sat, s_prev);
            end
            if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 0);
            xs = 0;
            if (rst) begin
                q.delete();
                exp_cnt = 0;
            end else begin
                if (m_valid && m_ready) begin
                    if (q.size() == 0) chk("spurious_out", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("m_data", m_data, e.x);
                        chk("m_sat", m_sat, e.s);
                        if (lat_chk) chk("latency", cyc - e.c, 2);
                        xs = e.s;
                    end
                end
                if (s_valid && s_ready) begin
                    r = ref_f(s_data);
                    e.x = r[15:0];
                    e.s = r[16];
                    e.c = cyc;
                    q.push_back(e);
                end
                if (clr_count) exp_cnt = 0;
                else if (xs && exp_cnt < 15) exp_cnt++;
            end
            stall_prev = m_valid && !m_ready && !rst;
            d_prev = m_data;
            s_prev = m_sat;
        end
    end

    task automatic send(input logic signed [15:0] y);
        int n = 0;
        s_valid = 1;
        s_data = y;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            if (++n > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 s_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [15:0] lin[5] = '{16'sd2048, 16'sd1, 16'sd4095, 16'sd3072, 16'sd1024};
        logic signed [15:0] sat[4] = '{16'sd0, -16'sd32768, 16'sd4096, 16'sd32767};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_sat", m_sat, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        mon_on = 1;
        lat_chk = 1;
        foreach (lin[i]) send(lin[i]);
        drain();
        foreach (sat[i]) send(sat[i]);
        drain();
        chk("sat_four", sat_count, 4);
        for (int i = 0; i < 6; i++) begin
            send(16'(i * 700 - 300));
            idle(1);
        end
        drain();
        lat_chk = 0;
        fork
            for (int i = 0; i < 6; i++) send(16'(i * 500 + 100));
            begin
                repeat (3) @(posedge clk);
                #1 m_ready = 0;
                @(negedge clk);
                chk("s_ready_bp", s_ready, 0);
                repeat (3) @(posedge clk);
                #1 m_ready = 1;
            end
        join
        drain();
        for (int i = 0; i < 20; i++) send(i % 2 ? 16'sd5000 : -16'sd5);
        drain();
        chk("sat_cap", sat_count, 15);
        clr_count = 1;
        @(posedge clk);
        #1 clr_count = 0;
        chk("clr", sat_count, 0);
        send(-16'sd100);
        @(posedge clk);
        #1 clr_count = 1;
        chk("coincide_pending", m_valid, 1);
        @(posedge clk);
        #1 clr_count = 0;
        chk("clr_vs_inc", sat_count, 0);
        drain();
        send(-16'sd1);
        drain();
        chk("pre_rst_cnt", sat_count, 1);
        send(16'sd2048);
        send(16'sd3000);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_sat", m_sat, 0);
        chk("mid_rst_sat_count", sat_count, 0);
        idle(4);
        chk("no_stale", q.size(), 0);
        lat_chk = 1;
        send(16'sd1);
        send(16'sd4095);
        drain();
        chk("final_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
